// File: rtl/pe_io_pkg.sv
// Shared types and constants for the PE result UART transmit path.
// Build option: PE_UART_TX_PARITY_EN adds an even-parity bit to every frame.
package pe_io_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3
`ifdef PE_UART_TX_PARITY_EN
    , TX_PARITY = 3'd4
`endif
  } tx_state_t;

`ifdef PE_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic UART_IDLE_LVL = 1'b1;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer: start bit, 8 data bits LSB first, optional even
// parity (PE_UART_TX_PARITY_EN), stop bit; each bit lasts CLKS_PER_BIT cycles.
module uart_byte_tx
  import pe_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk460k,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       frame_done
);

  localparam int                TMR_W    = cnt_w(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = TX_IDLE;
  localparam logic [2:0] S_START  = TX_START;
  localparam logic [2:0] S_DATA   = TX_DATA;
  localparam logic [2:0] S_STOP   = TX_STOP;
`ifdef PE_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = TX_PARITY;
`endif

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
`ifdef PE_UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             bit_end;
  logic             load;

  assign bit_end = (timer_q == TMR_LAST);
  // A new byte is taken from idle, or straight out of the last stop cycle so
  // consecutive frames have no gap.
  assign load    = start && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left one
    // unassigned would make synthesis infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
`ifdef PE_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != S_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef PE_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef PE_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d  = S_START;
      shift_d  = byte_in;
`ifdef PE_UART_TX_PARITY_EN
      parity_d = ^byte_in;
`endif
    end
  end

  // Line level is decoded from state so an asynchronous reset forces idle-high
  // without waiting for a clock edge.
  always_comb begin
    tx = UART_IDLE_LVL;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[0];
`ifdef PE_UART_TX_PARITY_EN
      S_PARITY: tx = parity_q;
`endif
      default:  tx = UART_IDLE_LVL;
    endcase
  end

  // NOTE: sequential state is written with non-blocking (<=) so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk460k or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef PE_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef PE_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: rtl/pe_result_uart_tx.sv
// PE result word -> UART: latches one DATA_W word per handshake and sends it
// byte 0 first as back-to-back frames (parity with PE_UART_TX_PARITY_EN).
module pe_result_uart_tx
  import pe_io_pkg::*;
#(
  parameter int DATA_W       = 208,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk460k,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic              UART_TX,
  output logic              busy,
  output logic              tx_done
);

  localparam int               NBYTES   = nbytes(DATA_W);
  localparam int               IDX_W    = cnt_w(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  logic [NBYTES-1:0][7:0] word_q, word_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d, next_idx;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;
  logic                   accept, last_byte, frame_done, next_byte, byte_start;
  logic [7:0]             byte_val;

  assign din_rdy   = rst_n && en && !busy_q;
  assign accept    = din_vld && din_rdy;
  assign last_byte = (byte_idx_q == IDX_LAST);
  assign next_idx  = byte_idx_q + 1'b1;

  always_comb begin
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
    next_byte  = 1'b0;
    if (accept) begin
      word_d     = din;
      byte_idx_d = '0;
      busy_d     = 1'b1;
    end else if (frame_done) begin
      if (last_byte) begin
        busy_d    = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        byte_idx_d = next_idx;
        next_byte  = 1'b1;
      end
    end
  end

  // The first byte bypasses word_q so its START cycle follows the accept edge.
  assign byte_start = accept || next_byte;
  assign byte_val   = accept ? din[7:0] : word_q[next_idx];

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk460k    (clk460k),
    .rst_n      (rst_n),
    .start      (byte_start),
    .byte_in    (byte_val),
    .tx         (UART_TX),
    .frame_done (frame_done)
  );

  // NOTE: word_q is a bank of flops, not a RAM, so it takes the async reset like
  // the rest of the state and never powers up holding stale data.
  always_ff @(posedge clk460k or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_pe_result_uart_tx.sv
// Self-checking bench for pe_result_uart_tx: table-driven words, scoreboard of
// accepted words compared bit-by-bit on the serial line, plus corner sequences.
module tb_pe_result_uart_tx;
  import pe_io_pkg::*;

  localparam int DATA_W = 208;
  localparam int CPB    = 4;
  localparam int NB     = DATA_W / 8;
  localparam int T      = NB * FRAME_BITS * CPB;

  logic              clk460k = 1'b0;
  logic              rst_n, en, din_vld, din_rdy, UART_TX, busy, tx_done;
  logic [DATA_W-1:0] din;

  typedef struct {
    logic [DATA_W-1:0] word;
    int                start;
  } sb_t;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic              par0;
  } vec_t;

  sb_t  sb[$];
  sb_t  cur;
  vec_t vecs[4];
  bit   act = 1'b0;
  int   n_checks = 0, n_err = 0;
  int   cyc = 0, free_cyc = 0, idle_mism = 0, mism = 0, t_off = 0;

  pe_result_uart_tx #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk460k (clk460k),
    .rst_n   (rst_n),
    .en      (en),
    .din     (din),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .UART_TX (UART_TX),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk460k = ~clk460k;

  initial forever begin
    @(posedge clk460k);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got cycle %0d, want completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input logic ok, input string name,
                       input logic [63:0] act_v, input logic [63:0] exp_v);
    n_checks++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act_v, exp_v);
    end
  endtask

  // Expected line level t cycles after the first START cycle of word w.
  function automatic logic exp_line(input logic [DATA_W-1:0] w, input int t);
    int         k, b;
    logic [7:0] by;
    k  = t / (FRAME_BITS * CPB);
    b  = (t % (FRAME_BITS * CPB)) / CPB;
    by = w[8*k +: 8];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (FRAME_BITS == 11 && b == 9) return ^by;
    return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk460k);
    #1;
  endtask

  // Drive a word; the bench's own model says when it is accepted.
  task automatic send_word(input logic [DATA_W-1:0] w, output int s);
    din     = w;
    din_vld = 1'b1;
    s       = ((cyc > free_cyc) ? cyc : free_cyc) + 1;
    sb.push_back('{w, s});
    free_cyc = s + T;
    while (cyc < s) tick(1);
  endtask

  task automatic wait_idle();
    while (cyc <= free_cyc) tick(1);
    tick(2);
  endtask

  // Line monitor: every cycle compared against the scoreboard head.
  initial forever begin
    @(negedge clk460k);
    if (!rst_n) begin
      if (act) check(mism == 0, "abandoned_stream", 64'(mism), 64'd0);
      act = 1'b0;
      sb.delete();
      if (UART_TX !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || din_rdy !== 1'b0)
        idle_mism++;
    end else begin
      if (!act && sb.size() > 0 && sb[0].start == cyc) begin
        cur  = sb.pop_front();
        act  = 1'b1;
        mism = 0;
      end
      if (act) begin
        t_off = cyc - cur.start;
        if (t_off < T) begin
          if (UART_TX !== exp_line(cur.word, t_off) || busy !== 1'b1 ||
              tx_done !== 1'b0 || din_rdy !== 1'b0)
            mism++;
        end else begin
          check(tx_done === 1'b1 && busy === 1'b0 && UART_TX === 1'b1 && din_rdy === en,
                "word_end", 64'({tx_done, busy, UART_TX, din_rdy}), 64'({3'b101, en}));
          check(mism == 0, "word_stream", 64'(mism), 64'd0);
          act = 1'b0;
        end
      end else if (UART_TX !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || din_rdy !== en) begin
        idle_mism++;
      end
    end
  end

  initial begin
    logic [21:0]       cap;
    logic [7:0]        fb;
    logic [DATA_W-1:0] w;
    int                s, s2, cnt, off;

    vecs[0] = '{208'h0A55, 8'h55, 8'h0A, 1'b0};
    vecs[1] = '{208'h07FF, 8'hFF, 8'h07, 1'b0};
    vecs[2] = '{{192'hDEADBEEF_CAFEF00D, 16'h3C81}, 8'h81, 8'h3C, 1'b0};
    vecs[3] = '{{192'h1234_5678, 16'h0007}, 8'h07, 8'h00, 1'b1};

    // Reset and first cycle after release
    rst_n = 1'b0; en = 1'b1; din_vld = 1'b0; din = '0;
    tick(5);
    check(din_rdy === 1'b0, "rst_din_rdy", 64'(din_rdy), 64'd0);
    check(UART_TX === 1'b1, "rst_line", 64'(UART_TX), 64'd1);
    rst_n = 1'b1;
    #1;
    check(din_rdy === 1'b1, "post_rst_din_rdy", 64'(din_rdy), 64'd1);
    check(UART_TX === 1'b1 && busy === 1'b0 && tx_done === 1'b0, "post_rst_idle",
          64'({UART_TX, busy, tx_done}), 64'b100);
    free_cyc = cyc;

    // Table: first two frames decoded at bit centres
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].din, s);
      din_vld = 1'b0;
      for (int b = 0; b < 2 * FRAME_BITS; b++) begin
        while (cyc < s + b * CPB + CPB / 2) tick(1);
        cap[b] = UART_TX;
      end
      fb = cap[8:1];
      check(cap[0] === 1'b0 && fb === vecs[i].b0, "frame0_byte", 64'({cap[0], fb}), 64'(vecs[i].b0));
      check(cap[9] === ((FRAME_BITS == 11) ? vecs[i].par0 : 1'b1), "frame0_bit9",
            64'(cap[9]), 64'((FRAME_BITS == 11) ? vecs[i].par0 : 1'b1));
      fb = cap[FRAME_BITS + 8 -: 8];
      check(cap[FRAME_BITS] === 1'b0 && fb === vecs[i].b1, "frame1_byte",
            64'({cap[FRAME_BITS], fb}), 64'(vecs[i].b1));
      wait_idle();
    end

    // Word time from first START cycle to tx_done
    send_word(vecs[0].din, s);
    din_vld = 1'b0;
    cnt = 0;
    while (tx_done !== 1'b1 && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    check(cnt == ((FRAME_BITS == 11) ? 1144 : 1040), "word_time", 64'(cnt),
          64'((FRAME_BITS == 11) ? 1144 : 1040));
    wait_idle();

    // Back-to-back with din_vld held high
    send_word(vecs[1].din, s);
    din = vecs[2].din;
    while (cyc < s + T) tick(1);
    check(tx_done === 1'b1 && UART_TX === 1'b1 && din_rdy === 1'b1, "b2b_gap",
          64'({tx_done, UART_TX, din_rdy}), 64'b111);
    send_word(vecs[2].din, s2);
    din_vld = 1'b0;
    check(UART_TX === 1'b0 && busy === 1'b1, "b2b_start", 64'({UART_TX, busy}), 64'b01);
    wait_idle();

    // Hold-off: din and din_vld churn while busy
    send_word(vecs[3].din, s);
    din_vld = 1'b0;
    while (cyc < free_cyc - 1) begin
      for (int k = 0; k < NB; k++) din[8*k +: 8] = 8'($urandom);
      din_vld = 1'($urandom);
      tick(1);
    end
    din_vld = 1'b0;
    wait_idle();

    // en gating in idle, then en dropped mid-word
    en = 1'b0; din_vld = 1'b1; din = 208'hBAD;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (din_rdy !== 1'b0 || UART_TX !== 1'b1 || busy !== 1'b0) cnt++;
    end
    check(cnt == 0, "en_block", 64'(cnt), 64'd0);
    din_vld = 1'b0; en = 1'b1;
    tick(1);
    send_word(vecs[2].din, s);
    din_vld = 1'b0;
    tick(100);
    en = 1'b0;
    cnt = 0;
    while (tx_done !== 1'b1 && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    check(tx_done === 1'b1, "en_drop_done", 64'(tx_done), 64'd1);
    wait_idle();
    en = 1'b1;
    tick(1);

    // Reset during a DATA bit of byte 3 (byte 3 is 0x00, so the line is low)
    w = {176'hABCDEF, 32'h0033_2211};
    send_word(w, s);
    din_vld = 1'b0;
    off = 3 * FRAME_BITS * CPB + CPB + 2;
    while (cyc < s + off) tick(1);
    check(UART_TX === 1'b0, "pre_reset_line", 64'(UART_TX), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check(UART_TX === 1'b1 && busy === 1'b0, "reset_async_line", 64'({UART_TX, busy}), 64'b10);
    tick(3);
    rst_n = 1'b1;
    free_cyc = cyc;
    cnt = 0;
    for (int k = 0; k < 3 * FRAME_BITS * CPB; k++) begin
      tick(1);
      if (tx_done !== 1'b0) cnt++;
    end
    check(cnt == 0, "no_done_after_reset", 64'(cnt), 64'd0);
    send_word(vecs[3].din, s);
    din_vld = 1'b0;
    wait_idle();

    check(idle_mism == 0, "idle_line", 64'(idle_mism), 64'd0);
    check(sb.size() == 0 && act == 1'b0, "sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
